// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA scan timing generator with pixel-enable divider
// Counters, syncs and video_on move together on the pixel_tick edge.
module vga_sync #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int CLK_DIV   = 4
) (
   input  logic       clk_d,
   input  logic       rst,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       pixel_tick,
   output logic       frame_start
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS     = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS     = 10'(V_DISPLAY);
   localparam logic [9:0] HS_FIRST  = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST  = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [3:0] div_cnt_q, div_cnt_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       video_on_q, video_on_d;

   // Gated by rst so a CLK_DIV=1 build does not show a tick while held in reset.
   assign pixel_tick  = !rst && (div_cnt_q == DIV_LAST);
   assign frame_start = pixel_tick && (x_q == H_LAST) && (y_q == V_LAST);

   always_comb begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
      x_d       = x_q;
      y_d       = y_q;
      if (pixel_tick) begin
         if (x_q == H_LAST) begin
            x_d = 10'd0;
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
      // Decoded from next-state counters so the registered flags line up with them.
      hsync_d    = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
      vsync_d    = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
      video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
   end

   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         div_cnt_q  <= 4'd0;
         x_q        <= 10'd0;
         y_q        <= 10'd0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
      end
   end

   assign pixel_x  = x_q;
   assign pixel_y  = y_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = video_on_q;

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Timing generator that sits directly upstream of pixel_gen.
- Produces the pixel_x/pixel_y scan coordinates that pixel_gen colours, plus the hsync/vsync pulses driven to the VGA connector.
- Fixed 640x480@60 Hz industry timing by default, with a 25 MHz pixel rate derived from the 100 MHz board clock via a pixel-enable tick.
- Also provides video_on and a per-frame strobe that the game FSM uses for animation/timeout pacing.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, clk_d cycles per pixel; legal range 1..16

Ports:
- clk_d  in  1  system clock, 100 MHz
- rst  in  1  asynchronous active-high reset
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
- pixel_tick  out  1  one-clk_d pulse per pixel period
- frame_start  out  1  one-clk_d pulse at the end of each frame

Behaviour:
- Derived constants:
  - H_TOTAL = sum of H_* (800 by default).
  - V_TOTAL = sum of V_* (525 by default).
- Reset is asynchronous, active-high. While rst is high:
  - The divider count, pixel_x and pixel_y are 0.
  - hsync=1, vsync=1, video_on=0, pixel_tick=0, frame_start=0.
- Divider:
  - A 4-bit div_cnt counts 0..CLK_DIV-1 and wraps, incrementing every clk_d edge.
  - pixel_tick is combinationally high while div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick is constantly high outside reset.
- Counters:
  - pixel_x and pixel_y are registers and advance only on an edge where pixel_tick=1.
  - pixel_x increments. At H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y wraps from V_TOTAL-1 to 0 when pixel_x also wraps.
  - Each counter value is held for exactly CLK_DIV clk_d cycles.
- Sync and video_on:
  - hsync, vsync and video_on are registered.
  - Each is computed from the next-state counter values so it changes on the same clk_d edge as the counters and is always aligned with them (zero relative latency).
  - hsync=0 iff H_DISPLAY+H_FRONT <= pixel_x <= H_DISPLAY+H_FRONT+H_SYNC-1. Default: 656..751.
  - vsync=0 iff V_DISPLAY+V_FRONT <= pixel_y <= V_DISPLAY+V_FRONT+V_SYNC-1. Default: 490..491.
  - video_on=1 iff pixel_x<H_DISPLAY and pixel_y<V_DISPLAY.
- After reset release:
  - On the first clk_d edge, video_on goes to 1 (counters at 0,0).
  - hsync and vsync stay at 1.
- frame_start:
  - Combinational: pixel_tick && pixel_x==H_TOTAL-1 && pixel_y==V_TOTAL-1.
  - High for exactly one clk_d cycle per frame, on the cycle immediately preceding the wrap to (0,0).
- Pixel period timing:
  - No output may glitch within a pixel period.
  - pixel_gen samples pixel_x/pixel_y on clk_d, so its colour outputs lag the coordinates by one clk_d; this is within one pixel period for CLK_DIV>=2.
- Frame length: H_TOTAL*V_TOTAL*CLK_DIV clk_d cycles, i.e. 1,680,000 by default.
- Reset mid-operation:
  - All state returns immediately (asynchronously) to the reset values.
  - The next frame after release starts at (0,0) with div_cnt=0. No partial sync pulse is stretched or completed.
- Width rules:
  - Counters are 10 bits. Parameter sets with H_TOTAL or V_TOTAL > 1024 are illegal.
  - Comparisons are unsigned.

Test Plan:
- Reset and divider: assert rst for 5 clk_d, then release.
  - Required during reset: pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0.
  - Required after release: pixel_tick on cycles 4, 8, 12…; pixel_x=1 after the 4th edge.
- Horizontal timing, line 0:
  - hsync falls when pixel_x becomes 656 and rises when pixel_x becomes 752, giving 384 clk_d low.
  - video_on falls when pixel_x becomes 640.
  - pixel_x wraps 799→0 with pixel_y 0→1.
- Vertical timing:
  - vsync low exactly while pixel_y ∈ {490, 491}, i.e. 2×800×4 = 6400 clk_d.
  - video_on stays 0 for every pixel_x while pixel_y ≥ 480.
- Frame period:
  - frame_start pulses exactly once per 1,680,000 clk_d cycles, each pulse 1 clk_d wide.
  - The first pulse occurs at cycle 1,680,000 after release, with pixel_x=799 and pixel_y=524; the next edge shows 0,0.
- Mid-frame reset: assert rst at pixel_x=700, pixel_y=300 (hsync low).
  - Required: outputs go to reset values without waiting for a clock edge.
  - Required after release: the next frame starts from 0,0; hsync next falls at x=656.
- CLK_DIV=1 build:
  - Required: pixel_tick is constantly 1 and the counters advance every clk_d.
  - Required: frame_start period is 420,000 cycles and the hsync low width is 96 clk_d.
